// File: rtl/bp_pkg.sv
// Shared definitions for the two-level local-history branch predictor.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package bp_pkg;

    // Default geometry.
    localparam int BP_PC_W      = 32;
    localparam int BP_BHT_IDX_W = 4;
    localparam int BP_HIST_W    = 4;
    localparam int BP_PC_BITS   = 3;
    localparam int BP_PC_LSB    = 0;
    localparam int BP_CTR_W     = 2;
    localparam int BP_CTR_INIT  = 1;   // weakly not-taken for a 2-bit counter

    // Upper bounds for the fold helper's fixed-width arguments.
    localparam int BP_PC_MAX_W    = 64;
    localparam int BP_FOLD_MAX_W  = 16;
    localparam int BP_FOLD_SEL_W  = 4;

    typedef enum logic {
        INIT,
        RUN
    } bp_state_e;

    // XOR-fold of pc in idx_w-bit chunks, LSB first. Bit i of the PC lands on
    // bit (i mod idx_w) of the result, which zero-pads a short top chunk.
    function automatic logic [BP_FOLD_MAX_W-1:0] bp_fold(
        input logic [BP_PC_MAX_W-1:0] pc,
        input int                     pc_w,
        input int                     idx_w
    );
        logic [BP_FOLD_MAX_W-1:0] acc;
        logic [BP_FOLD_SEL_W-1:0] j;
        acc = '0;
        j   = '0;
        for (int i = 0; i < BP_PC_MAX_W; i++) begin
            if (i < pc_w) begin
                acc[j] = acc[j] ^ pc[i];
                j = (int'(j) == idx_w - 1) ? '0 : j + BP_FOLD_SEL_W'(1);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Saturating up/down counter next-state: +1 on taken, -1 on not-taken, clamped.
// Latency: combinational.
// Backpressure: none.
// Ports: ctr (current value), taken (resolved direction), ctr_next (result).
module sat_counter_next #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr_next
);

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) ctr_next = ctr + CTR_W'(1);
        end else begin
            if (ctr != '0) ctr_next = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_2lvl.sv
// Two-level local-history branch predictor: BHT of shift histories indexes a PHT of counters.
// Latency: prediction registered, valid one cycle after an accepted request; clear takes max(BHT,PHT) depth cycles.
// Backpressure: ready_o low during table clear; requests and updates seen while not ready are dropped.
// Ports: clk/resetn (sync, active-low); pred_req_i/pc_i lookup in; pred_valid_o/taken_o/pht_idx_o/bht_idx_o
//        registered prediction out; upd_valid_i/upd_pht_idx_i/upd_bht_idx_i/upd_taken_i retire training in.
module branch_predictor_2lvl
    import bp_pkg::*;
#(
    parameter int PC_W      = BP_PC_W,
    parameter int BHT_IDX_W = BP_BHT_IDX_W,
    parameter int HIST_W    = BP_HIST_W,
    parameter int PC_BITS   = BP_PC_BITS,
    parameter int PC_LSB    = BP_PC_LSB,
    parameter int CTR_W     = BP_CTR_W,
    parameter int CTR_INIT  = BP_CTR_INIT
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      pred_req_i,
    input  logic [PC_W-1:0]           pc_i,
    output logic                      ready_o,
    output logic                      pred_valid_o,
    output logic                      taken_o,
    output logic [PC_BITS+HIST_W-1:0] pht_idx_o,
    output logic [BHT_IDX_W-1:0]      bht_idx_o,
    input  logic                      upd_valid_i,
    input  logic [PC_BITS+HIST_W-1:0] upd_pht_idx_i,
    input  logic [BHT_IDX_W-1:0]      upd_bht_idx_i,
    input  logic                      upd_taken_i
);

    localparam int PHT_IDX_W = PC_BITS + HIST_W;
    localparam int BHT_DEPTH = 1 << BHT_IDX_W;
    localparam int PHT_DEPTH = 1 << PHT_IDX_W;
    localparam int CLR_DEPTH = (BHT_DEPTH > PHT_DEPTH) ? BHT_DEPTH : PHT_DEPTH;
    localparam int PTR_W     = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;

    logic [HIST_W-1:0] bht [BHT_DEPTH];
    logic [CTR_W-1:0]  pht [PHT_DEPTH];

    bp_state_e         state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic              run;
    logic              upd_fire;
    logic              lk_fire;
    logic [HIST_W-1:0] upd_hist;
    logic [CTR_W-1:0]  upd_ctr;
    logic [BHT_IDX_W-1:0] lk_bht_idx;
    logic [HIST_W-1:0]    lk_hist;
    logic [PHT_IDX_W-1:0] lk_pht_idx;
    logic [CTR_W-1:0]     lk_ctr;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                ptr_d = ptr_q + PTR_W'(1);
                if (ptr_q == PTR_W'(CLR_DEPTH - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign run      = (state_q == RUN);
    assign ready_o  = run;
    assign upd_fire = run & upd_valid_i;
    assign lk_fire  = run & pred_req_i;

    // ---------------- update datapath ----------------
    // Dropping the top bit of {hist, taken} shifts the outcome in at the LSB.
    assign upd_hist = HIST_W'({bht[upd_bht_idx_i], upd_taken_i});

    sat_counter_next #(.CTR_W(CTR_W)) u_ctr_next (
        .ctr      (pht[upd_pht_idx_i]),
        .taken    (upd_taken_i),
        .ctr_next (upd_ctr)
    );

    // ---------------- lookup with same-cycle forwarding ----------------
    // The history is forwarded first, so the PHT index (and hence the counter
    // forward decision) is formed from the post-update history.
    assign lk_bht_idx = BHT_IDX_W'(bp_fold(BP_PC_MAX_W'(pc_i), PC_W, BHT_IDX_W));
    assign lk_hist    = (upd_fire && lk_bht_idx == upd_bht_idx_i) ? upd_hist : bht[lk_bht_idx];
    assign lk_pht_idx = {pc_i[PC_LSB +: PC_BITS], lk_hist};
    assign lk_ctr     = (upd_fire && lk_pht_idx == upd_pht_idx_i) ? upd_ctr : pht[lk_pht_idx];

    // ---------------- tables ----------------
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            if (int'(ptr_q) < BHT_DEPTH) bht[ptr_q[BHT_IDX_W-1:0]] <= '0;
            if (int'(ptr_q) < PHT_DEPTH) pht[ptr_q[PHT_IDX_W-1:0]] <= CTR_W'(CTR_INIT);
        end else if (upd_valid_i) begin
            bht[upd_bht_idx_i] <= upd_hist;
            pht[upd_pht_idx_i] <= upd_ctr;
        end
    end

    // ---------------- registered prediction ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pred_valid_o <= 1'b0;
            taken_o      <= 1'b0;
            pht_idx_o    <= '0;
            bht_idx_o    <= '0;
        end else begin
            pred_valid_o <= lk_fire;
            if (lk_fire) begin
                taken_o   <= lk_ctr[CTR_W-1];
                pht_idx_o <= lk_pht_idx;
                bht_idx_o <= lk_bht_idx;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Self-checking bench for branch_predictor_2lvl against an array-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_branch_predictor_2lvl;

    localparam int CLR_CYCLES = 128;
    localparam int TAKEN_THR  = 2;   // counter >= 2 predicts taken for 2-bit counters

    logic       clk;
    logic       resetn;
    logic       pred_req_i;
    logic [31:0] pc_i;
    logic       ready_o;
    logic       pred_valid_o;
    logic       taken_o;
    logic [6:0] pht_idx_o;
    logic [3:0] bht_idx_o;
    logic       upd_valid_i;
    logic [6:0] upd_pht_idx_i;
    logic [3:0] upd_bht_idx_i;
    logic       upd_taken_i;

    branch_predictor_2lvl dut (
        .clk           (clk),
        .resetn        (resetn),
        .pred_req_i    (pred_req_i),
        .pc_i          (pc_i),
        .ready_o       (ready_o),
        .pred_valid_o  (pred_valid_o),
        .taken_o       (taken_o),
        .pht_idx_o     (pht_idx_o),
        .bht_idx_o     (bht_idx_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pht_idx_i (upd_pht_idx_i),
        .upd_bht_idx_i (upd_bht_idx_i),
        .upd_taken_i   (upd_taken_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain integer arrays of histories and counters.
    int bht_m [16];
    int pht_m [128];
    bit m_run;
    int h_taken, h_pht, h_bht;   // expected held prediction outputs

    function automatic int fold_m(input logic [31:0] pc);
        int r = 0;
        for (int k = 0; k < 32; k += 4) r ^= int'((pc >> k) & 32'hF);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++)  bht_m[i] = 0;
        for (int i = 0; i < 128; i++) pht_m[i] = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check the registered outputs.
    task automatic cyc(input bit req, input logic [31:0] pc, input bit uv,
                       input int ubi, input int upi, input bit ut);
        bit fire;
        pred_req_i    = req;
        pc_i          = pc;
        upd_valid_i   = uv;
        upd_bht_idx_i = 4'(ubi);
        upd_pht_idx_i = 7'(upi);
        upd_taken_i   = ut;
        // A same-cycle lookup sees the table as it is after the update.
        if (m_run && uv) begin
            bht_m[ubi] = ((bht_m[ubi] << 1) | int'(ut)) & 15;
            if (ut) pht_m[upi] = (pht_m[upi] >= 3) ? 3 : pht_m[upi] + 1;
            else    pht_m[upi] = (pht_m[upi] <= 0) ? 0 : pht_m[upi] - 1;
        end
        fire = m_run && req && resetn;
        if (fire) begin
            h_bht   = fold_m(pc);
            h_pht   = (int'(pc & 32'h7) << 4) | bht_m[h_bht];
            h_taken = (pht_m[h_pht] >= TAKEN_THR) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        chk("pred_valid", 32'(pred_valid_o), 32'(fire));
        chk("taken",      32'(taken_o),      32'(h_taken));
        chk("pht_idx",    32'(pht_idx_o),    32'(h_pht));
        chk("bht_idx",    32'(bht_idx_o),    32'(h_bht));
    endtask

    task automatic cyc_garbage();
        cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    endtask

    // Runs the clear with resetn high; returns cycles until ready_o rose.
    task automatic run_init(input bit garbage, output int n);
        m_run = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (garbage) cyc_garbage();
            else         cyc(1'b0, 32'h0, 1'b0, 0, 0, 1'b0);
            n++;
            if (ready_o) break;
        end
        model_clear();
        m_run = 1'b1;
    endtask

    initial begin
        int n;
        int ubi, upi, newh;
        bit ut;
        logic [31:0] pc;

        resetn = 1'b0;
        pred_req_i = 1'b0; pc_i = '0; upd_valid_i = 1'b0;
        upd_bht_idx_i = '0; upd_pht_idx_i = '0; upd_taken_i = 1'b0;
        m_run = 1'b0; h_taken = 0; h_pht = 0; h_bht = 0;
        model_clear();

        // Reset state.
        repeat (3) cyc(1'b1, 32'h5, 1'b1, 5, 'h50, 1'b1);
        chk("ready_in_reset", 32'(ready_o), 32'd0);

        // Clear length from an idle start.
        resetn = 1'b1;
        run_init(1'b0, n);
        chk("init_len", 32'(n), 32'(CLR_CYCLES));
        chk("ready_after_init", 32'(ready_o), 32'd1);

        // Basic lookup, then an idle cycle holds the outputs.
        cyc(1'b1, 32'h5, 1'b0, 0, 0, 1'b0);
        chk("lk5_bht", 32'(bht_idx_o), 32'h5);
        chk("lk5_pht", 32'(pht_idx_o), 32'h50);
        chk("lk5_taken", 32'(taken_o), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 0, 0, 1'b0);

        // Saturating up: PHT 0x50 observed through pc 0x15 (BHT 4, history 0).
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 32'h0, 1'b1, 5, 'h50, 1'b1);
            cyc(1'b1, 32'h15, 1'b0, 0, 0, 1'b0);
        end
        chk("sat_hi_taken", 32'(taken_o), 32'd1);
        cyc(1'b1, 32'h5, 1'b0, 0, 0, 1'b0);
        chk("hist_0111", 32'(pht_idx_o), 32'h57);

        // Saturating down.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 32'h0, 1'b1, 5, 'h50, 1'b0);
            cyc(1'b1, 32'h15, 1'b0, 0, 0, 1'b0);
        end
        chk("sat_lo_taken", 32'(taken_o), 32'd0);
        cyc(1'b1, 32'h5, 1'b0, 0, 0, 1'b0);
        chk("hist_0000", 32'(pht_idx_o), 32'h50);

        // Forwarding of history, then of the counter.
        cyc(1'b1, 32'h5, 1'b1, 5, 'h50, 1'b1);
        chk("fwd_hist_pht", 32'(pht_idx_o), 32'h51);
        chk("fwd_hist_taken", 32'(taken_o), 32'd0);
        cyc(1'b1, 32'h15, 1'b1, 9, 'h50, 1'b1);
        chk("fwd_ctr_pht", 32'(pht_idx_o), 32'h50);
        chk("fwd_ctr_taken", 32'(taken_o), 32'd1);

        // Random traffic with frequent forwarding hits.
        for (int i = 0; i < 400; i++) begin
            pc = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
            ut = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) != 0) begin
                ubi  = fold_m(pc);
                newh = ((bht_m[ubi] << 1) | int'(ut)) & 15;
                upi  = (int'(pc & 32'h7) << 4) | newh;
            end else begin
                ubi = int'($urandom_range(0, 15));
                upi = int'($urandom_range(0, 127));
            end
            cyc(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)), ubi, upi, ut);
        end

        // Reset from RUN, then a reset pulse at clear pointer 60.
        m_run = 1'b0;
        resetn = 1'b0;
        h_taken = 0; h_pht = 0; h_bht = 0;
        cyc_garbage();
        resetn = 1'b1;
        for (int i = 0; i < 60; i++) cyc_garbage();
        chk("ready_mid_init", 32'(ready_o), 32'd0);
        resetn = 1'b0;
        cyc_garbage();
        resetn = 1'b1;
        run_init(1'b1, n);
        chk("init_len_restart", 32'(n), 32'(CLR_CYCLES));

        // Tables hold their cleared values despite traffic during the clear.
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 0, 0, 1'b0);
            chk("cleared_taken", 32'(taken_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor_2lvl.md
Name: branch_predictor_2lvl

Overview:
Parametrised two-level local-history branch predictor. It is the successor to the fixed 16-entry BHT / 128-entry PHT predictor. It sits in fetch: it takes a fetch PC, returns a registered taken/not-taken prediction with the table indices used, and accepts retire-stage updates. New relative to the previous generation: generic table sizes and counter width, a multi-cycle table-clear state machine, a request/valid handshake, same-cycle update forwarding, and a correct shift-in of history.

Parameters:
PC_W, 32, fetch PC width
BHT_IDX_W, 4, BHT index width; BHT depth = 2**BHT_IDX_W
HIST_W, 4, local history bits per BHT entry
PC_BITS, 3, PC bits concatenated above history in the PHT index; PHT_IDX_W = PC_BITS+HIST_W
PC_LSB, 0, lowest PC bit used for PHT concatenation
CTR_W, 2, saturating counter width
CTR_INIT, 1, counter value loaded at clear (weakly not-taken for CTR_W=2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
pred_req_i  in  1  lookup request
pc_i  in  PC_W  fetch PC
ready_o  out  1  high when tables are initialised and lookups/updates are accepted
pred_valid_o  out  1  prediction valid, one cycle after an accepted request
taken_o  out  1  predicted direction
pht_idx_o  out  PHT_IDX_W  PHT index used; carried down the pipe to retire
bht_idx_o  out  BHT_IDX_W  BHT index used; carried down the pipe to retire
upd_valid_i  in  1  retire update
upd_pht_idx_i  in  PHT_IDX_W  PHT entry to train
upd_bht_idx_i  in  BHT_IDX_W  BHT entry to shift
upd_taken_i  in  1  resolved branch outcome

Behaviour:
- Reset is resetn, synchronous and active-low, on clock clk. While resetn=0: ready_o=0, pred_valid_o=0, taken_o=0, pht_idx_o=0, bht_idx_o=0, FSM=INIT, clear pointer=0.
- FSM states:
  - INIT: each cycle writes BHT[ptr]=0 (when ptr < BHT depth) and PHT[ptr]=CTR_INIT, then ptr++. Leaves INIT after ptr reaches max(BHT depth, PHT depth)-1. Takes 128 cycles at default parameters.
  - RUN: ready_o=1.
- resetn low mid-INIT or mid-RUN returns the FSM to INIT with ptr=0; a full clear follows.
- In INIT, pred_req_i and upd_valid_i are ignored and tables are not modified by them; pred_valid_o stays 0.
- BHT index: XOR-fold of pc_i in BHT_IDX_W-bit chunks, LSB-first; the top chunk is zero-padded if PC_W is not a multiple of BHT_IDX_W.
- PHT index: {pc_i[PC_LSB+PC_BITS-1:PC_LSB], BHT[bht_idx]}.
- Lookup: combinational table read in the request cycle. Results are registered, so pred_valid_o, taken_o, pht_idx_o and bht_idx_o appear the next cycle. pred_valid_o = registered (pred_req_i & ready_o).
- taken_o = counter MSB.
- Without a request, pred_valid_o=0 and the other prediction outputs hold their last values.
- Update (RUN, upd_valid_i=1), applied at the clock edge:
  - BHT[upd_bht_idx_i] <= {hist[HIST_W-2:0], upd_taken_i}.
  - PHT[upd_pht_idx_i] <= saturating counter: +1 if taken, -1 if not taken; saturates at 2**CTR_W-1 and at 0, never wrapping.
- Forwarding: when a lookup and an update occur in the same cycle:
  - If the lookup BHT index equals upd_bht_idx_i, the lookup uses the updated history.
  - If the resulting PHT index equals upd_pht_idx_i, the lookup uses the updated counter value.
  - The prediction therefore equals the value a lookup one cycle later would have returned.
- Back-to-back updates to the same entry accumulate: each cycle's update sees the previous cycle's written value.

Decomposition:
- Shared package bp_pkg: default widths, CTR_INIT, fold-hash function, and the FSM state enum (INIT, RUN).
- One sub-module, sat_counter_next: combinational CTR_W-bit saturating next-state (inputs old value and taken). It is used both for the update write and for the forwarding path.
- Tables are inferred flop arrays in the top module.

Test Plan:
- Reset, then idle -> ready_o=0 for exactly 128 cycles; ready_o=1 on cycle 129; every PHT entry reads 1 and taken_o=0 for any PC.
- Lookup pc=0x0000_0005 after INIT -> bht_idx_o=0x5 and pht_idx_o=0x50 one cycle later; taken_o=0; pred_valid_o pulses for 1 cycle.
- Three taken updates to PHT 0x50 / BHT 5 -> counter goes 1→2→3→3 (saturates); BHT[5] history goes 0001→0011→0111. Four not-taken updates -> counter goes to 0 and stays at 0.
- Update BHT 5 taken with PHT 0x50 while a lookup of pc=0x5 occurs in the same cycle -> lookup uses history 0001 and pht_idx_o=0x51 (forwarded). Second check: with lookup PHT index equal to the update index, the forwarded counter value is reflected in taken_o.
- resetn pulsed low for 1 cycle at INIT ptr=60 -> clear restarts; ready_o rises 128 cycles after resetn returns high.
- pred_req_i and upd_valid_i asserted during INIT -> pred_valid_o=0 throughout; after INIT, all tables hold their cleared values.
